imem_loader: RTL and testbench

- Program loader: the write-side counterpart of the instruction memory.
- Accepts a framed byte stream over a valid/ready byte interface, for example from a UART receiver.
- Assembles little-endian 32-bit instruction words and drives the instruction memory write port, one word per write, starting at word 0.
- Asserts `busy` while loading so the core can be held in reset; pulses `done` when the program is in memory.

---
 rtl/imem_loader.sv | 157 +++++++++++++++
 tb/tb_imem_loader.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Program loader: framed byte stream in, little-endian 32-bit words out
// to the instruction memory write port, one word per write from word 0.
module imem_loader #(
  parameter int          DEPTH     = 1024,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        imem_we,
  output logic [31:0] imem_waddr,
  output logic [31:0] imem_wdata,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [15:0] words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_WRITE,
    S_FINISH,
    S_ERR
  } state_t;

  localparam logic [16:0] DEPTH_L = 17'(DEPTH);

  state_t      state;
  state_t      state_nx;
  logic [7:0]  len_lo;
  logic [15:0] len;
  logic [1:0]  byte_cnt;
  logic [23:0] word_buf;
  logic [15:0] word_index;
  logic [15:0] len_in;
  logic [15:0] index_nx;
  logic        accept;
  logic        is_sync;

  assign rx_ready = (state == S_IDLE)   ||
                    (state == S_LEN_LO) ||
                    (state == S_LEN_HI) ||
                    (state == S_DATA);

  assign busy = (state == S_LEN_LO) ||
                (state == S_LEN_HI) ||
                (state == S_DATA)   ||
                (state == S_WRITE);

  assign accept   = rx_valid && rx_ready;
  assign is_sync  = (rx_data == SYNC_BYTE);
  assign len_in   = {rx_data, len_lo};
  assign index_nx = word_index + 16'd1;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // rx_valid alone gates transitions: rx_ready is 1 in every state that
  // consumes bytes, so this matches accept without a comb loop.
  always_comb begin
    state_nx = state;
    imem_we  = 1'b0;
    done     = 1'b0;
    error    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (rx_valid && is_sync) state_nx = S_LEN_LO;
      end
      S_LEN_LO: begin
        if (rx_valid) state_nx = S_LEN_HI;
      end
      S_LEN_HI: begin
        if (rx_valid) begin
          if (len_in == 16'd0)
            state_nx = S_FINISH;
          else if ({1'b0, len_in} > DEPTH_L)
            state_nx = S_ERR;
          else
            state_nx = S_DATA;
        end
      end
      S_DATA: begin
        if (rx_valid && byte_cnt == 2'd3)
          state_nx = S_WRITE;
      end
      S_WRITE: begin
        imem_we  = 1'b1;
        state_nx = (index_nx == len) ? S_FINISH : S_DATA;
      end
      S_FINISH: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      S_ERR: begin
        error = 1'b1;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_lo       <= 8'd0;
      len          <= 16'd0;
      byte_cnt     <= 2'd0;
      word_buf     <= 24'd0;
      word_index   <= 16'd0;
      words_loaded <= 16'd0;
      imem_waddr   <= 32'd0;
      imem_wdata   <= 32'd0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (accept && is_sync) begin
            words_loaded <= 16'd0;
            word_index   <= 16'd0;
            byte_cnt     <= 2'd0;
          end
        end
        S_LEN_LO: begin
          if (accept) len_lo <= rx_data;
        end
        S_LEN_HI: begin
          if (accept) len <= len_in;
        end
        S_DATA: begin
          if (accept) begin
            byte_cnt <= byte_cnt + 2'd1;
            unique case (byte_cnt)
              2'd0: word_buf[7:0]   <= rx_data;
              2'd1: word_buf[15:8]  <= rx_data;
              2'd2: word_buf[23:16] <= rx_data;
              2'd3: begin
                imem_wdata <= {rx_data, word_buf};
                imem_waddr <= {14'd0, word_index, 2'b00};
              end
              default: ;
            endcase
          end
        end
        S_WRITE: begin
          word_index   <= index_nx;
          words_loaded <= words_loaded + 16'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: frames in, expected writes and done
// events queued by a word-level model, popped by a negedge monitor.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        imem_we;
  logic [31:0] imem_waddr;
  logic [31:0] imem_wdata;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] words_loaded;

  imem_loader dut (
    .clk          (clk),
    .rst          (rst),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .imem_we      (imem_we),
    .imem_waddr   (imem_waddr),
    .imem_wdata   (imem_wdata),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_done;
    logic [31:0] a;
    logic [31:0] d;
  } ev_t;

  ev_t         exp_q[$];
  logic [7:0]  tx_q[$];
  logic [31:0] wq[$];
  int          tests = 0;
  int          fails = 0;
  bit          gap_en = 1'b0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
    ev_t e;
    e.is_done = 1'b0;
    e.a = a;
    e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic push_done(input logic [31:0] n);
    ev_t e;
    e.is_done = 1'b1;
    e.a = 32'd0;
    e.d = n;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (imem_we) begin
        check("we_rx_ready", {31'd0, rx_ready}, 32'd0);
        check("we_busy", {31'd0, busy}, 32'd1);
        if (exp_q.size() == 0 || exp_q[0].is_done) begin
          tests++;
          fails++;
          $display("FAIL unexpected_write: addr %h data %h",
                   imem_waddr, imem_wdata);
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          check("waddr", imem_waddr, e.a);
          check("wdata", imem_wdata, e.d);
        end
      end
      if (done) begin
        check("done_rx_ready", {31'd0, rx_ready}, 32'd0);
        check("done_busy", {31'd0, busy}, 32'd0);
        if (exp_q.size() == 0 || !exp_q[0].is_done) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done: words_loaded %0d",
                   words_loaded);
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          check("done_words", {16'd0, words_loaded}, e.d);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    bit acc;
    if (gap_en) begin
      int g;
      g = $urandom_range(0, 3);
      rx_valid = 1'b0;
      repeat (g) begin
        @(posedge clk);
        #1;
      end
    end
    rx_data  = b;
    rx_valid = 1'b1;
    n   = 0;
    acc = 1'b0;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = rx_ready;
      @(posedge clk);
      #1;
      n++;
    end
    rx_valid = 1'b0;
    if (!acc) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: byte %h never accepted", b);
    end
  endtask

  task automatic send_all();
    while (tx_q.size() != 0) send_byte(tx_q.pop_front());
  endtask

  // Word-level model: a frame of N words yields writes at i*4 then done(N).
  task automatic load_words();
    int n;
    n = wq.size();
    tx_q.push_back(8'hA5);
    tx_q.push_back(n[7:0]);
    tx_q.push_back(n[15:8]);
    for (int i = 0; i < n; i++) begin
      logic [31:0] w;
      w = wq[i];
      for (int k = 0; k < 4; k++) tx_q.push_back(8'((w >> (8 * k))));
      push_wr(32'(i * 4), w);
    end
    push_done(32'(n));
    send_all();
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check(nm, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_we", {31'd0, imem_we}, 32'd0);
    check("rst_waddr", imem_waddr, 32'd0);
    check("rst_wdata", imem_wdata, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
    check("rst_words", {16'd0, words_loaded}, 32'd0);
    check("rst_rx_ready", {31'd0, rx_ready}, 32'd1);
    rst = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    #1;
    do_reset();

    tx_q = '{8'hA5, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
             8'hB3, 8'h86, 8'h99, 8'h01};
    push_wr(32'd0, 32'h00000000);
    push_wr(32'd4, 32'h019986B3);
    push_done(32'd2);
    send_all();
    drain("two_word_drain");
    check("two_word_words", {16'd0, words_loaded}, 32'd2);

    tx_q = '{8'h00, 8'hFF, 8'h13, 8'hA5, 8'h01, 8'h00,
             8'h93, 8'h04, 8'h14, 8'h00};
    push_wr(32'd0, 32'h00140493);
    push_done(32'd1);
    send_all();
    drain("noise_drain");

    tx_q = '{8'hA5, 8'h00, 8'h00};
    push_done(32'd0);
    send_all();
    drain("n0_drain");

    gap_en = 1'b1;
    repeat (6) begin
      int junk;
      int n;
      junk = $urandom_range(0, 3);
      for (int j = 0; j < junk; j++) begin
        logic [7:0] b;
        b = 8'($urandom);
        if (b == 8'hA5) b = 8'h5A;
        tx_q.push_back(b);
      end
      n = $urandom_range(1, 8);
      wq.delete();
      for (int i = 0; i < n; i++) wq.push_back($urandom);
      load_words();
      drain("rand_drain");
    end
    gap_en = 1'b0;

    tx_q = '{8'hA5, 8'h04, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11,
             8'h88, 8'h77};
    push_wr(32'd0, 32'h11223344);
    send_all();
    repeat (2) @(posedge clk);
    #1;
    check("midload_pending", 32'(exp_q.size()), 32'd0);
    do_reset();
    tx_q = '{8'hA5, 8'h01, 8'h00, 8'h63, 8'h86, 8'h94, 8'h00};
    push_wr(32'd0, 32'h00948663);
    push_done(32'd1);
    send_all();
    drain("midload_drain");
    check("midload_words", {16'd0, words_loaded}, 32'd1);

    tx_q = '{8'hA5, 8'h01, 8'h04};
    send_all();
    repeat (3) @(posedge clk);
    #1;
    check("err_error", {31'd0, error}, 32'd1);
    check("err_busy", {31'd0, busy}, 32'd0);
    check("err_rx_ready", {31'd0, rx_ready}, 32'd0);
    rx_data  = 8'hA5;
    rx_valid = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    rx_valid = 1'b0;
    check("err_sticky", {31'd0, error}, 32'd1);
    check("err_words", {16'd0, words_loaded}, 32'd0);
    do_reset();

    wq.delete();
    for (int i = 0; i < 1024; i++) wq.push_back(32'hC0DE0000 + 32'(i));
    load_words();
    drain("full_drain");
    check("full_last_addr", imem_waddr, 32'h00000FFC);
    check("full_error", {31'd0, error}, 32'd0);
    check("full_words", {16'd0, words_loaded}, 32'd1024);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

endmodule
